// File: rtl/dbgapb_host_pkg.sv
// dbgapb_host_pkg: register offsets, debug instruction codes, enums and the per-command step table
package dbgapb_host_pkg;

    localparam logic [7:0] OFF_DBG_EN   = 8'h00;
    localparam logic [7:0] OFF_INST     = 8'h04;
    localparam logic [7:0] OFF_INST_WR  = 8'h08;
    localparam logic [7:0] OFF_WDATA    = 8'h0C;
    localparam logic [7:0] OFF_WDATA_WR = 8'h10;
    localparam logic [7:0] OFF_RDATA    = 8'h14;

    localparam logic [11:0] CODE_ATTACH     = 12'h001;
    localparam logic [11:0] CODE_RESUME     = 12'h002;
    localparam logic [11:0] CODE_INSTREG_WR = 12'h003;
    localparam logic [11:0] CODE_EXECUTE    = 12'h004;
    localparam logic [11:0] CODE_STATUS_RD  = 12'h005;
    localparam logic [11:0] CODE_PC_RD      = 12'h006;
    localparam logic [11:0] CODE_GPR_RD     = 12'h007;
    localparam logic [11:0] CODE_CSR_RD     = 12'h008;
    localparam logic [11:0] CODE_GPR_WR     = 12'h009;
    localparam logic [11:0] CODE_CSR_WR     = 12'h00A;

    localparam logic [3:0] STRB_ALL = 4'hF;

    typedef enum logic [3:0] {
        OP_ATTACH, OP_RESUME, OP_STATUS_RD, OP_PC_RD, OP_GPR_RD,
        OP_CSR_RD, OP_GPR_WR, OP_CSR_WR, OP_EXEC
    } cmd_op_e;

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP, ST_RESP} state_e;

    // One APB step: register offset, direction, write data, and whether it
    // is followed by the bus-idle gap or ends the command.
    typedef struct packed {
        logic [7:0]  off;
        logic        wr;
        logic [31:0] wd;
        logic        gap;
        logic        last;
    } step_t;

    function automatic step_t mk(input logic [7:0] off, input logic wr, input logic [31:0] wd,
                                 input logic gap, input logic last);
        return {off, wr, wd, gap, last};
    endfunction

    function automatic logic [31:0] inst(input logic [11:0] a, input logic [11:0] c);
        return {4'b0, a, 4'b0, c};
    endfunction

    function automatic logic [11:0] op_code(input cmd_op_e op);
        case (op)
            OP_ATTACH:    return CODE_ATTACH;
            OP_RESUME:    return CODE_RESUME;
            OP_STATUS_RD: return CODE_STATUS_RD;
            OP_PC_RD:     return CODE_PC_RD;
            OP_GPR_RD:    return CODE_GPR_RD;
            OP_CSR_RD:    return CODE_CSR_RD;
            OP_GPR_WR:    return CODE_GPR_WR;
            OP_CSR_WR:    return CODE_CSR_WR;
            default:      return 12'h000;
        endcase
    endfunction

    // Step 0 is always the DBG_EN write; command-specific steps start at 1.
    function automatic step_t get_step(input cmd_op_e op, input logic [2:0] i,
                                       input logic [11:0] a, input logic [31:0] d);
        step_t s;
        logic [31:0] ic;
        ic = inst(a, op_code(op));
        s = mk(OFF_DBG_EN, 1'b1, 32'd1, 1'b0, 1'b0);
        if (i != 3'd0) begin
            case (op)
                OP_ATTACH, OP_RESUME:
                    s = i == 3'd1 ? mk(OFF_INST, 1'b1, inst(12'h0, op_code(op)), 1'b0, 1'b0)
                                  : mk(OFF_INST_WR, 1'b1, 32'd1, 1'b0, 1'b1);
                OP_STATUS_RD, OP_PC_RD, OP_GPR_RD, OP_CSR_RD:
                    s = i == 3'd1 ? mk(OFF_INST, 1'b1, ic, 1'b0, 1'b0)
                      : i == 3'd2 ? mk(OFF_INST_WR, 1'b1, 32'd1, 1'b1, 1'b0)
                                  : mk(OFF_RDATA, 1'b0, 32'd0, 1'b0, 1'b1);
                OP_GPR_WR, OP_CSR_WR:
                    s = i == 3'd1 ? mk(OFF_WDATA, 1'b1, d, 1'b0, 1'b0)
                      : i == 3'd2 ? mk(OFF_WDATA_WR, 1'b1, 32'd1, 1'b0, 1'b0)
                      : i == 3'd3 ? mk(OFF_INST, 1'b1, ic, 1'b0, 1'b0)
                                  : mk(OFF_INST_WR, 1'b1, 32'd1, 1'b0, 1'b1);
                default:
                    s = i == 3'd1 ? mk(OFF_WDATA, 1'b1, d, 1'b0, 1'b0)
                      : i == 3'd2 ? mk(OFF_WDATA_WR, 1'b1, 32'd1, 1'b0, 1'b0)
                      : i == 3'd3 ? mk(OFF_INST, 1'b1, inst(12'h0, CODE_INSTREG_WR), 1'b0, 1'b0)
                      : i == 3'd4 ? mk(OFF_INST_WR, 1'b1, 32'd1, 1'b0, 1'b0)
                      : i == 3'd5 ? mk(OFF_INST, 1'b1, inst(12'h0, CODE_EXECUTE), 1'b0, 1'b0)
                                  : mk(OFF_INST_WR, 1'b1, 32'd1, 1'b0, 1'b1);
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/dbgapb_host_xfer.sv
// dbgapb_host_xfer: one APB transfer (SETUP then ACCESS until pready or timeout)
//   start            load address/data/direction and enter SETUP next cycle
//   ld_addr/ld_wdata/ld_write  transfer parameters sampled with start
//   done/err         combinational completion and error of the current ACCESS cycle
//   psel..pwdata     registered APB master outputs; pready/pslverr APB response
// Optional DBGAPB_HOST_TIMEOUT_EN: abort ACCESS after TIMEOUT wait cycles.
module dbgapb_host_xfer
    import dbgapb_host_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        start,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    input  logic        ld_write,
    input  logic        pready,
    input  logic        pslverr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [3:0]  pstrb,
    output logic [31:0] pwdata,
    output logic        done,
    output logic        err
);

    logic to;

`ifdef DBGAPB_HOST_TIMEOUT_EN
    logic [9:0] cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) cnt <= '0;
        else          cnt <= (penable && !pready) ? cnt + 10'd1 : 10'd0;
    end

    assign to = penable && !pready && cnt == 10'(TIMEOUT - 1);
`else
    assign to = 1'b0;
`endif

    assign done = penable && (pready || to);
    assign err  = penable && ((pready && pslverr) || to);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pstrb   <= '0;
            pwdata  <= '0;
        end else if (start) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= ld_write;
            paddr   <= ld_addr;
            pstrb   <= ld_write ? STRB_ALL : 4'h0;
            pwdata  <= ld_wdata;
        end else if (done) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end else if (psel) begin
            penable <= 1'b1;
        end
    end

endmodule

// File: rtl/dbgapb_host.sv
// dbgapb_host: sequences debug commands into APB register accesses on a debug port
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata  command request
//   rsp_valid/rsp_rdata/rsp_err                    one-cycle completion pulse, data held
//   psel/penable/pwrite/paddr/pstrb/pwdata         APB master; prdata/pready/pslverr response
// Optional DBGAPB_HOST_TIMEOUT_EN: ACCESS phases time out after TIMEOUT cycles.
module dbgapb_host
    import dbgapb_host_pkg::*;
#(
    parameter logic [31:0] PADDR_BASE = 32'h0,
    parameter int          TIMEOUT    = 1023
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [11:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [3:0]  pstrb,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pslverr,
    input  logic        pready
);

    state_e      state, state_n;
    cmd_op_e     op_q, ld_op;
    logic [11:0] addr_q, ld_addr;
    logic [31:0] wdata_q, ld_wdata;
    logic [2:0]  idx, ld_i;
    logic [1:0]  gap_cnt;
    logic        rdy, accept, start, done, xerr, en_done, last_q, gap_q;
    step_t       ld;

    assign cmd_ready = rdy;
    assign accept    = cmd_valid && rdy;

    // The step loaded on entry to SETUP: from the live command on accept
    // (skipping the DBG_EN step once enabled), otherwise the step after idx.
    always_comb begin
        ld_op    = state == ST_IDLE ? cmd_op_e'(cmd_op) : op_q;
        ld_addr  = state == ST_IDLE ? cmd_addr : addr_q;
        ld_wdata = state == ST_IDLE ? cmd_wdata : wdata_q;
        ld_i     = state == ST_IDLE ? {2'b0, en_done} : idx + 3'd1;
        ld       = get_step(ld_op, ld_i, ld_addr, ld_wdata);
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (accept) state_n = cmd_op <= 4'd8 ? ST_SETUP : ST_RESP;
            ST_SETUP:  state_n = ST_ACCESS;
            ST_ACCESS: if (done) state_n = (xerr || last_q) ? ST_RESP : gap_q ? ST_GAP : ST_SETUP;
            ST_GAP:    if (gap_cnt == 2'd2) state_n = ST_SETUP;
            default:   state_n = ST_IDLE;
        endcase
        start = state_n == ST_SETUP;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rdy       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            op_q      <= OP_ATTACH;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            en_done   <= 1'b0;
            last_q    <= 1'b0;
            gap_q     <= 1'b0;
        end else begin
            rdy       <= state_n == ST_IDLE;
            rsp_valid <= state_n == ST_RESP;
            gap_cnt   <= state == ST_GAP ? gap_cnt + 2'd1 : 2'd0;
            if (accept) begin
                op_q    <= cmd_op_e'(cmd_op);
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (start) begin
                idx    <= ld_i;
                last_q <= ld.last;
                gap_q  <= ld.gap;
            end
            if (state == ST_ACCESS && done && !xerr && idx == 3'd0) en_done <= 1'b1;
            // Only the RDATA step is a read, so a clean read completion carries the result.
            if (state_n == ST_RESP) begin
                rsp_err   <= state == ST_IDLE || xerr;
                rsp_rdata <= (state == ST_ACCESS && !pwrite && !xerr) ? prdata : 32'd0;
            end
        end
    end

    dbgapb_host_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
        .pclk     (pclk),
        .presetn  (presetn),
        .start    (start),
        .ld_addr  (PADDR_BASE + {24'b0, ld.off}),
        .ld_wdata (ld.wd),
        .ld_write (ld.wr),
        .pready   (pready),
        .pslverr  (pslverr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pstrb    (pstrb),
        .pwdata   (pwdata),
        .done     (done),
        .err      (xerr)
    );

endmodule
